// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: segment layout and hex glyph table shared by the
// 7-segment scan driver and its decoder.
package seg_scan_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_G  = 0;

  localparam logic [7:0] DP_MASK  = 8'h80;
  localparam logic [7:0] SEG_DARK = 8'h00;

  // {a,b,c,d,e,f,g} per hex value, entry 0 in the low bits
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: display data in, digit enables and segments out.
// master = datapath side, slave = scan driver.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 2
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [BRIGHT_W-1:0]     bright;
  logic [NUM_DIGITS-1:0]   en;
  logic [7:0]              disp;
  logic                    frame_start;

  modport master (
    output digits, dp, blank, bright,
    input  en, disp, frame_start
  );

  modport slave (
    input  digits, dp, blank, bright,
    output en, disp, frame_start
  );

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex value plus decimal point to {dp,a..g}.
// Purely combinational.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg                = SEG_DARK;
    seg[SEG_A:SEG_G]   = GLYPH_TBL[val];
    seg[SEG_DP]        = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit 7-seg scan with frame snapshot
// and PWM; SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1,
  parameter int BRIGHT_W   = 2
) (
  input  logic     clk_1khz,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int PW = DW + BRIGHT_W + 2;
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);

  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [BRIGHT_W-1:0]     snap_bright_q, snap_bright_d;
  logic                    stg_vld_q, stg_vld_d;
  logic [IW-1:0]           stg_idx_q, stg_idx_d;
  logic [DW-1:0]           stg_dwell_q, stg_dwell_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [7:0]              disp_q, disp_d;
  logic                    fs_q, fs_d;

  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_val;
  logic                    cur_dp;
  logic [7:0]              cur_seg;
  logic [PW-1:0]           pwm_lhs, pwm_rhs;
  logic                    lit;

  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q + 1'b1;
    if (dwell_q == DWELL_MAX) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  assign frame_tick = (idx_q == '0) && (dwell_q == '0);

  always_comb begin
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    snap_bright_d = snap_bright_q;
    if (frame_tick) begin
      snap_digits_d = bus.digits;
      snap_dp_d     = bus.dp;
      snap_blank_d  = bus.blank;
      snap_bright_d = bus.bright;
    end
    stg_vld_d   = 1'b1;
    stg_idx_d   = idx_q;
    stg_dwell_d = dwell_q;
  end

`ifdef SEG_SCAN_LZB_EN
  logic zero_run;

  // a digit stays dark while it and everything above it is a bare zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run
               && (snap_digits_q[4*i +: 4] == 4'h0)
               && !snap_dp_q[i];
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign cur_val = snap_digits_q[{stg_idx_q, 2'b00} +: 4];
  assign cur_dp  = snap_dp_q[stg_idx_q];

  seg_hex_decode u_dec (
    .val (cur_val),
    .dp  (cur_dp),
    .seg (cur_seg)
  );

  // duty compare: dwell * 2^BRIGHT_W < (bright + 1) * DWELL
  assign pwm_lhs = PW'(stg_dwell_q) << BRIGHT_W;
  assign pwm_rhs = (PW'(snap_bright_q) + PW'(1)) * PW'(DWELL);

  assign lit = stg_vld_q
            && !snap_blank_q[stg_idx_q]
            && !lz_mask[stg_idx_q]
            && (pwm_lhs < pwm_rhs);

  always_comb begin
    en_d   = '1;
    disp_d = SEG_DARK;
    if (lit) begin
      en_d[stg_idx_q] = 1'b0;
      disp_d          = cur_seg;
    end
    fs_d = stg_vld_q && (stg_idx_q == '0) && (stg_dwell_q == '0);
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      idx_q         <= '0;
      dwell_q       <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_bright_q <= '0;
      stg_vld_q     <= 1'b0;
      stg_idx_q     <= '0;
      stg_dwell_q   <= '0;
      en_q          <= '1;
      disp_q        <= SEG_DARK;
      fs_q          <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      dwell_q       <= dwell_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      snap_bright_q <= snap_bright_d;
      stg_vld_q     <= stg_vld_d;
      stg_idx_q     <= stg_idx_d;
      stg_dwell_q   <= stg_dwell_d;
      en_q          <= en_d;
      disp_q        <= disp_d;
      fs_q          <= fs_d;
    end
  end

  assign bus.en          = en_q;
  assign bus.disp        = disp_q;
  assign bus.frame_start = fs_q;

endmodule
